// File: rtl/wb_fetch_pkg.sv
// Shared types and constants for the Wishbone burst fetch engine.
//   state_e   : control FSM states of wb_burst_fetch
//   CTI_*     : Wishbone B3 cycle type identifiers used by the initiator
//   BTE_*     : burst type extension (only linear bursts are issued)
//   cti_for() : cycle type for a beat, given whether it is the last of its burst
package wb_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPACE,
        BURST,
        RETRY_GAP,
        FINISH
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    function automatic logic [2:0] cti_for(input logic last_beat);
        return last_beat ? CTI_END : CTI_INCR;
    endfunction

endpackage

// File: rtl/wb_fetch_fifo.sv
// First-word-fall-through FIFO holding fetched words until the stream drains them.
//   clk, rst  : clock, asynchronous active-high reset (pointers/count only)
//   push_i    : write wdata_i (caller guarantees there is room)
//   pop_i     : consume the head word; ignored while empty
//   flush_i   : discard all contents; wins over push/pop in the same cycle
//   rdata_o   : head word, valid whenever empty_o is low
//   empty_o   : no words stored
//   free_o    : number of unused entries
module wb_fetch_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [CW-1:0]    free_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths also work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign free_o  = CW'(DEPTH) - count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_i, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/wb_burst_fetch.sv
// Wishbone B3 read initiator: fetches word_count_i words starting at base_adr_i
// with incrementing bursts and streams them out through an internal FWFT FIFO.
// A burst is only issued when the FIFO can absorb every beat of it.
//   clk, rst        : clock, asynchronous active-high reset
//   wb_*_o / wb_*_i : Wishbone B3 master port (32-bit data, byte address)
//   start_i         : one-cycle request, honoured only while busy_o is low
//   base_adr_i      : first byte address (bits [1:0] ignored)
//   word_count_i    : number of words to fetch (0 = immediate done)
//   abort_i         : cancel the active transfer and flush the FIFO
//   busy_o          : transfer in progress
//   done_o          : one-cycle pulse at the end of a transfer (normal or err)
//   error_o         : sticky bus-error flag, cleared by the next accepted start
//   dat_o, valid_o, ready_i : output word stream
module wb_burst_fetch
    import wb_fetch_pkg::*;
#(
    parameter int BURST_LEN   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [3:0]             wb_sel_o,
    output logic [31:0]            wb_adr_o,
    output logic [31:0]            wb_dat_o,
    output logic [2:0]             wb_cti_o,
    output logic [1:0]             wb_bte_o,
    input  logic [31:0]            wb_dat_i,
    input  logic                   wb_ack_i,
    input  logic                   wb_err_i,
    input  logic                   wb_rty_i,
    input  logic                   start_i,
    input  logic [31:0]            base_adr_i,
    input  logic [COUNT_WIDTH-1:0] word_count_i,
    input  logic                   abort_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [31:0]            dat_o,
    output logic                   valid_o,
    input  logic                   ready_i
);

    localparam int BW = $clog2(BURST_LEN) + 1;
    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    state_e                 state_q, state_d;
    logic [31:0]            adr_q, adr_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic                   cyc_q, cyc_d;
    logic [2:0]             cti_q, cti_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic                   fifo_push, fifo_flush, fifo_empty;
    logic [FW-1:0]          fifo_free;
    logic [BW-1:0]          beats;
    logic                   space_ok;

    assign beats    = (rem_q >= COUNT_WIDTH'(BURST_LEN)) ? BW'(BURST_LEN) : BW'(rem_q);
    assign space_ok = (fifo_free >= FW'(beats));

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        rem_d      = rem_q;
        beat_d     = beat_q;
        cyc_d      = cyc_q;
        cti_d      = cti_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    adr_d   = base_adr_i & 32'hFFFF_FFFC;
                    rem_d   = word_count_i;
                    error_d = 1'b0;
                    if (word_count_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = WAIT_SPACE;
                    end
                end
            end
            // RETRY_GAP already spent its one idle cycle, so it may re-issue at once.
            WAIT_SPACE, RETRY_GAP: begin
                if (space_ok) begin
                    cyc_d   = 1'b1;
                    beat_d  = beats;
                    cti_d   = cti_for(beats == BW'(1));
                    state_d = BURST;
                end else begin
                    state_d = WAIT_SPACE;
                end
            end
            BURST: begin
                if (wb_err_i) begin
                    cyc_d   = 1'b0;
                    cti_d   = CTI_CLASSIC;
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = FINISH;
                end else if (wb_rty_i) begin
                    cyc_d   = 1'b0;
                    cti_d   = CTI_CLASSIC;
                    state_d = RETRY_GAP;
                end else if (wb_ack_i) begin
                    fifo_push = 1'b1;
                    adr_d     = adr_q + 32'd4;
                    rem_d     = rem_q - COUNT_WIDTH'(1);
                    beat_d    = beat_q - BW'(1);
                    if (beat_q == BW'(1)) begin
                        // Dropping cyc here guarantees the idle cycle between bursts.
                        cyc_d = 1'b0;
                        cti_d = CTI_CLASSIC;
                        if (rem_q == COUNT_WIDTH'(1)) begin
                            done_d  = 1'b1;
                            state_d = FINISH;
                        end else begin
                            state_d = WAIT_SPACE;
                        end
                    end else if (beat_q == BW'(2)) begin
                        cti_d = CTI_END;
                    end
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including an ack or err in the same cycle.
        if (abort_i && state_q != IDLE) begin
            state_d    = IDLE;
            cyc_d      = 1'b0;
            cti_d      = CTI_CLASSIC;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            error_d    = error_q;
            fifo_push  = 1'b0;
            fifo_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
            cyc_q   <= 1'b0;
            cti_q   <= CTI_CLASSIC;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            rem_q   <= rem_d;
            beat_q  <= beat_d;
            cyc_q   <= cyc_d;
            cti_q   <= cti_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    wb_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (wb_dat_i),
        .pop_i   (ready_i),
        .flush_i (fifo_flush),
        .rdata_o (dat_o),
        .empty_o (fifo_empty),
        .free_o  (fifo_free)
    );

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = 1'b0;
    assign wb_sel_o = 4'hF;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = '0;
    assign wb_cti_o = cti_q;
    assign wb_bte_o = BTE_LINEAR;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign error_o  = error_q;
    assign valid_o  = !fifo_empty;

endmodule

// File: tb/tb_wb_burst_fetch.sv
// Bench for wb_burst_fetch: a zero-wait Wishbone slave model with one-shot
// err/rty injection by address, a stream consumer, and scoreboards for the
// expected bus beats (address + cti) and the expected stream words.
module tb_wb_burst_fetch;

    localparam int FIFO_DEPTH = 16;

    typedef struct packed {
        logic [31:0] adr;
        logic [2:0]  cti;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i, wb_rty_i;
    logic        start_i;
    logic [31:0] base_adr_i;
    logic [15:0] word_count_i;
    logic        abort_i;
    logic        busy_o, done_o, error_o;
    logic [31:0] dat_o;
    logic        valid_o, ready_i;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    beat_t       beat_q[$];

    logic        err_arm, rty_arm, err_now;
    logic [31:0] err_adr, rty_adr;
    int          ack_cnt, done_cnt, rises, inflight;
    logic        cyc_prev;
    int          gap_run, min_gap, max_gap;

    always #5 clk = ~clk;

    wb_burst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_sel_o     (wb_sel_o),
        .wb_adr_o     (wb_adr_o),
        .wb_dat_o     (wb_dat_o),
        .wb_cti_o     (wb_cti_o),
        .wb_bte_o     (wb_bte_o),
        .wb_dat_i     (wb_dat_i),
        .wb_ack_i     (wb_ack_i),
        .wb_err_i     (wb_err_i),
        .wb_rty_i     (wb_rty_i),
        .start_i      (start_i),
        .base_adr_i   (base_adr_i),
        .word_count_i (word_count_i),
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .dat_o        (dat_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_1234;
    endfunction

    task automatic exp_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mem_word(base + 32'(4 * i)));
    endtask

    task automatic exp_beats(input logic [31:0] base, input int n, input logic end_last);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.adr = base + 32'(4 * i);
            b.cti = (end_last && i == n - 1) ? 3'b111 : 3'b010;
            beat_q.push_back(b);
        end
    endtask

    task automatic clear_stats();
        ack_cnt  = 0;
        done_cnt = 0;
        rises    = 0;
        err_now  = 1'b0;
        cyc_prev = wb_cyc_o;
        gap_run  = 0;
        min_gap  = 1000;
        max_gap  = 0;
    endtask

    // One clock cycle: slave responds to the current request, scoreboards
    // consume what will be accepted at the coming edge, then the edge passes.
    task automatic tick();
        beat_t       eb;
        logic [31:0] ew;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        wb_dat_i = mem_word(wb_adr_o);
        if (wb_cyc_o && wb_stb_o) begin
            if (err_arm && wb_adr_o == err_adr) begin
                wb_err_i = 1'b1;
                err_arm  = 1'b0;
                err_now  = 1'b1;
            end else if (rty_arm && wb_adr_o == rty_adr) begin
                wb_rty_i = 1'b1;
                rty_arm  = 1'b0;
            end else begin
                wb_ack_i = 1'b1;
            end
        end
        if (wb_ack_i) begin
            ack_cnt++;
            n_checks++;
            if (beat_q.size() == 0) begin
                $display("FAIL beat_extra: got adr=%h cti=%b, expected no beat", wb_adr_o, wb_cti_o);
            end else begin
                eb = beat_q.pop_front();
                if ({wb_adr_o, wb_cti_o} !== {eb.adr, eb.cti})
                    $display("FAIL beat: got adr=%h cti=%b, expected adr=%h cti=%b",
                             wb_adr_o, wb_cti_o, eb.adr, eb.cti);
                else n_pass++;
            end
            if (!abort_i) begin
                inflight++;
                n_checks++;
                if (inflight > FIFO_DEPTH)
                    $display("FAIL overflow: got %0d words held, expected at most %0d", inflight, FIFO_DEPTH);
                else n_pass++;
            end
        end
        if (valid_o && ready_i) begin
            n_checks++;
            inflight--;
            if (exp_q.size() == 0) begin
                $display("FAIL stream_extra: got %h, expected no word", dat_o);
            end else begin
                ew = exp_q.pop_front();
                if (dat_o !== ew) $display("FAIL stream: got %h, expected %h", dat_o, ew);
                else n_pass++;
            end
        end
        if (abort_i && busy_o) inflight = 0;
        if (done_o) done_cnt++;
        if (wb_cyc_o && !cyc_prev) begin
            rises++;
            if (rises > 1) begin
                if (gap_run < min_gap) min_gap = gap_run;
                if (gap_run > max_gap) max_gap = gap_run;
            end
        end
        gap_run  = wb_cyc_o ? 0 : gap_run + 1;
        cyc_prev = wb_cyc_o;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] n);
        base_adr_i   = base;
        word_count_i = n;
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
    endtask

    task automatic run_until_idle(input int max_cycles);
        int i;
        i = 0;
        while ((busy_o || valid_o) && i < max_cycles) begin
            tick();
            i++;
        end
        n_checks++;
        if (busy_o || valid_o) $display("FAIL timeout: got busy=%b valid=%b, expected both 0", busy_o, valid_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({wb_cyc_o, wb_stb_o, busy_o, valid_o} !== 4'b0000)
            $display("FAIL reset_during: got %b, expected 0000", {wb_cyc_o, wb_stb_o, busy_o, valid_o});
        else n_pass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o, wb_adr_o, wb_dat_o}
            !== {3'b000, 4'hF, 3'b000, 2'b00, 32'h0, 32'h0})
            $display("FAIL reset_bus: got cyc=%b stb=%b we=%b sel=%h cti=%b bte=%b adr=%h dat=%h, expected 0 0 0 f 000 00 0 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o, wb_adr_o, wb_dat_o);
        else n_pass++;
        n_checks++;
        if ({busy_o, done_o, error_o, valid_o} !== 4'b0000)
            $display("FAIL reset_status: got %b, expected 0000", {busy_o, done_o, error_o, valid_o});
        else n_pass++;
    endtask

    task automatic test_burst();
        ready_i = 1'b1;
        clear_stats();
        exp_words(32'h1000, 20);
        exp_beats(32'h1000, 8, 1'b1);
        exp_beats(32'h1020, 8, 1'b1);
        exp_beats(32'h1040, 4, 1'b1);
        do_start(32'h1000, 16'd20);
        run_until_idle(200);
        repeat (2) tick();
        n_checks++;
        if (rises !== 3) $display("FAIL burst_count: got %0d, expected 3", rises);
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1) $display("FAIL burst_done: got %0d pulses, expected 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (exp_q.size() + beat_q.size() !== 0)
            $display("FAIL burst_left: got %0d words %0d beats pending, expected 0 0", exp_q.size(), beat_q.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int i;
        ready_i = 1'b0;
        clear_stats();
        exp_words(32'h1000, 20);
        exp_beats(32'h1000, 8, 1'b1);
        exp_beats(32'h1020, 8, 1'b1);
        exp_beats(32'h1040, 4, 1'b1);
        do_start(32'h1000, 16'd20);
        i = 0;
        while (ack_cnt < 16 && i < 100) begin tick(); i++; end
        repeat (5) tick();
        n_checks++;
        if ({ack_cnt, wb_cyc_o, busy_o} !== {32'd16, 1'b0, 1'b1})
            $display("FAIL bp_stall: got acks=%0d cyc=%b busy=%b, expected 16 0 1", ack_cnt, wb_cyc_o, busy_o);
        else n_pass++;
        ready_i = 1'b1;
        repeat (4) tick();
        ready_i = 1'b0;
        i = 0;
        while (ack_cnt < 20 && i < 40) begin tick(); i++; end
        n_checks++;
        if (ack_cnt !== 20) $display("FAIL bp_resume: got %0d acks, expected 20", ack_cnt);
        else n_pass++;
        ready_i = 1'b1;
        run_until_idle(100);
        n_checks++;
        if ({rises, done_cnt, exp_q.size()} !== {32'd3, 32'd1, 32'd0})
            $display("FAIL bp_end: got bursts=%0d done=%0d left=%0d, expected 3 1 0", rises, done_cnt, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_err();
        int i;
        ready_i = 1'b1;
        clear_stats();
        err_adr = 32'h1008;
        err_arm = 1'b1;
        exp_words(32'h1000, 2);
        exp_beats(32'h1000, 2, 1'b0);
        do_start(32'h1000, 16'd20);
        i = 0;
        while (!err_now && i < 50) begin tick(); i++; end
        n_checks++;
        if ({err_now, wb_cyc_o, error_o, done_o} !== 4'b1011)
            $display("FAIL err_response: got seen=%b cyc=%b error=%b done=%b, expected 1 0 1 1",
                     err_now, wb_cyc_o, error_o, done_o);
        else n_pass++;
        run_until_idle(50);
        n_checks++;
        if ({done_cnt, exp_q.size(), beat_q.size()} !== {32'd1, 32'd0, 32'd0})
            $display("FAIL err_end: got done=%0d words=%0d beats=%0d, expected 1 0 0", done_cnt, exp_q.size(), beat_q.size());
        else n_pass++;
        exp_words(32'h2000, 1);
        exp_beats(32'h2000, 1, 1'b1);
        do_start(32'h2000, 16'd1);
        n_checks++;
        if (error_o !== 1'b0) $display("FAIL err_clear: got %b, expected 0", error_o);
        else n_pass++;
        run_until_idle(50);
    endtask

    task automatic test_retry();
        ready_i = 1'b1;
        clear_stats();
        rty_adr = 32'h1010;
        rty_arm = 1'b1;
        exp_words(32'h1000, 8);
        exp_beats(32'h1000, 4, 1'b0);
        exp_beats(32'h1010, 4, 1'b1);
        do_start(32'h1000, 16'd8);
        run_until_idle(100);
        n_checks++;
        if ({rises, min_gap, max_gap} !== {32'd2, 32'd1, 32'd1})
            $display("FAIL rty_gap: got bursts=%0d gaps=%0d..%0d, expected 2 1..1", rises, min_gap, max_gap);
        else n_pass++;
        n_checks++;
        if ({exp_q.size(), beat_q.size(), done_cnt} !== {32'd0, 32'd0, 32'd1})
            $display("FAIL rty_end: got words=%0d beats=%0d done=%0d, expected 0 0 1", exp_q.size(), beat_q.size(), done_cnt);
        else n_pass++;
    endtask

    task automatic test_short();
        ready_i = 1'b1;
        clear_stats();
        do_start(32'h3000, 16'd0);
        n_checks++;
        if ({done_o, busy_o, wb_cyc_o} !== 3'b100)
            $display("FAIL zero_start: got done=%b busy=%b cyc=%b, expected 1 0 0", done_o, busy_o, wb_cyc_o);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if ({done_o, rises, done_cnt} !== {1'b0, 32'd0, 32'd1})
            $display("FAIL zero_after: got done=%b bursts=%0d pulses=%0d, expected 0 0 1", done_o, rises, done_cnt);
        else n_pass++;
        clear_stats();
        exp_words(32'h3000, 1);
        exp_beats(32'h3000, 1, 1'b1);
        do_start(32'h3000, 16'd1);
        run_until_idle(50);
        n_checks++;
        if ({rises, ack_cnt, exp_q.size(), beat_q.size()} !== {32'd1, 32'd1, 32'd0, 32'd0})
            $display("FAIL single: got bursts=%0d acks=%0d words=%0d beats=%0d, expected 1 1 0 0",
                     rises, ack_cnt, exp_q.size(), beat_q.size());
        else n_pass++;
    endtask

    task automatic test_abort();
        int i;
        ready_i = 1'b0;
        clear_stats();
        exp_beats(32'h1000, 4, 1'b0);
        do_start(32'h1000, 16'd20);
        i = 0;
        while (ack_cnt < 3 && i < 50) begin tick(); i++; end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        n_checks++;
        if ({wb_cyc_o, valid_o, busy_o, done_o} !== 4'b0000)
            $display("FAIL abort: got cyc=%b valid=%b busy=%b done=%b, expected 0 0 0 0",
                     wb_cyc_o, valid_o, busy_o, done_o);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if ({done_cnt, beat_q.size(), error_o, valid_o} !== {32'd0, 32'd0, 1'b0, 1'b0})
            $display("FAIL abort_after: got done=%0d beats=%0d error=%b valid=%b, expected 0 0 0 0",
                     done_cnt, beat_q.size(), error_o, valid_o);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int i;
        ready_i = 1'b1;
        clear_stats();
        exp_words(32'h1000, 20);
        exp_beats(32'h1000, 8, 1'b1);
        do_start(32'h1000, 16'd20);
        i = 0;
        while (ack_cnt < 3 && i < 50) begin tick(); i++; end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({wb_cyc_o, wb_stb_o, busy_o, valid_o, done_o} !== 5'b00000)
            $display("FAIL async_rst: got cyc=%b stb=%b busy=%b valid=%b done=%b, expected all 0",
                     wb_cyc_o, wb_stb_o, busy_o, valid_o, done_o);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        beat_q.delete();
        inflight = 0;
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        wb_dat_i     = '0;
        wb_ack_i     = 1'b0;
        wb_err_i     = 1'b0;
        wb_rty_i     = 1'b0;
        start_i      = 1'b0;
        base_adr_i   = '0;
        word_count_i = '0;
        abort_i      = 1'b0;
        ready_i      = 1'b0;
        err_arm      = 1'b0;
        rty_arm      = 1'b0;
        err_adr      = '0;
        rty_adr      = '0;
        inflight     = 0;
        test_reset();
        test_burst();
        test_backpressure();
        test_err();
        test_retry();
        test_short();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_burst_fetch.md
Name: wb_burst_fetch

Overview:
Wishbone B3 initiator that fetches a block of 32-bit words from memory using incrementing bursts and presents them on a valid/ready stream. It is the master-side counterpart to our memory slaves: video/palette loaders and line-buffer fillers use it to pull data from RAM. The block contains an internal FIFO and only issues a burst when the FIFO has room for every beat of that burst.

Parameters:
BURST_LEN, 8, maximum beats per burst; power of 2, ≥1.
FIFO_DEPTH, 16, FIFO entries; power of 2, ≥ BURST_LEN.
COUNT_WIDTH, 16, width of word_count.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
bus  wishbone_b3.master  -  initiator side; 32-bit data, byte address
start  in  1  single-cycle request; accepted only when busy=0
base_adr  in  32  start byte address; bits [1:0] ignored
word_count  in  COUNT_WIDTH  number of words to fetch
abort  in  1  cancel the transfer in progress
busy  out  1  high from an accepted start until IDLE is re-entered
done  out  1  one-cycle pulse when a transfer ends (normally or after err)
error  out  1  sticky; set by bus.err, cleared by the next accepted start
dat  out  32  stream data (FIFO head)
valid  out  1  stream valid
ready  in  1  stream ready

Behaviour:
- Reset values: cyc=0, stb=0, we=0, sel=4'hF, cti=000, bte=00, adr=0, dat_m2s=0, busy=0, done=0, error=0, valid=0. FIFO is empty. State is IDLE.
- All bus outputs are registered. we is always 0. sel is always 4'hF. bte is always 00 (linear).
- IDLE:
  - On start: latch adr=base_adr with [1:0] cleared, latch remaining=word_count, clear error.
  - If word_count=0: pulse done on the next cycle, never assert cyc, busy stays 0.
  - Otherwise: set busy=1 and go to WAIT_SPACE.
- WAIT_SPACE:
  - beats = min(remaining, BURST_LEN).
  - When FIFO free entries ≥ beats: assert cyc and stb, load beat counter = beats, go to BURST.
  - cti=111 if beats=1, else 010.
- BURST, on each cycle with ack=1 and err=0:
  - Push dat_s2m into the FIFO.
  - adr += 4, with wrap modulo 2^32.
  - Decrement remaining and the beat counter.
  - cti becomes 111 when exactly one beat is left.
- End of burst:
  - On the ack of the final beat, cyc and stb go low on the next edge.
  - cyc stays low for at least one cycle between bursts (bus fairness).
  - Next state is FINISH if remaining=0, else WAIT_SPACE.
- err (takes priority over ack in the same cycle):
  - Beat is not pushed.
  - cyc/stb drop next edge, error=1, the rest of the transfer is discarded, go to FINISH.
- rty:
  - Beat is not pushed.
  - cyc/stb drop for exactly one cycle, then go to WAIT_SPACE.
  - The re-issue starts from the current adr with beats recomputed from remaining.
- FINISH: done=1 for one cycle, then busy=0 and IDLE. The FIFO keeps its contents and drains independently.
- abort, in any non-IDLE state:
  - cyc/stb drop next edge and the FIFO is flushed.
  - An ack in the abort cycle is discarded.
  - Go to IDLE with busy=0. No done pulse; error is unchanged.
- start while busy=1 is ignored.
- FIFO is first-word fall-through:
  - valid = !empty; pop on valid & ready.
  - A word acked at edge N is visible on dat/valid in cycle N+1.
  - Simultaneous push and pop are allowed at any fill level.
  - Overflow is impossible by construction; the bench asserts it never occurs.
- Asynchronous rst mid-burst returns every output to its reset value immediately.

Decomposition:
- Package wb_fetch_pkg holds:
  - state enum {IDLE, WAIT_SPACE, BURST, RETRY_GAP, FINISH};
  - constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_END=3'b111, BTE_LINEAR=2'b00.
- Sub-module wb_fetch_fifo: synchronous FWFT FIFO with parameters DEPTH and WIDTH. It provides push, pop, flush, empty, and a free-count output used by the space check.

Test Plan:
1. base_adr=0x1000, word_count=20, BURST_LEN=8, ready=1, zero-wait slave -> bursts of 8, 8 and 4 beats. cti is 010 on every beat except the last of each burst, which is 111. cyc is low ≥1 cycle between bursts. 20 words appear in address order 0x1000..0x104C. done pulses once.
2. Same as scenario 1 with ready=0 -> exactly 16 words fetched, then cyc stays low. Raising ready for 4 pops lets the 4-beat burst issue. Final stream order is intact.
3. err on beat 3 of the first burst -> only 2 words are output, cyc is low the next cycle, error=1, and done pulses. The next start clears error.
4. word_count=8, rty on beat 5 (adr 0x1010) -> one idle cycle, then a 4-beat burst from 0x1010 with cti 010,010,010,111. All 8 words arrive once each, in order.
5. word_count=0 -> done pulses the next cycle with no cyc. word_count=1 -> a single beat with cti=111 and one output word.
6. abort during beat 4 -> cyc low next edge, valid=0, busy=0, no done. Separately, async rst mid-burst -> cyc/stb/busy/valid are 0 with no clock edge.
